// File: rtl/mul_stage2.sv
// Reduces the 72-bit column-sum value P modulo p = 2^40 - C into five 8-bit limbs.
// Latency: result valid 3 cycles after the accept edge; one result per 5 cycles at best.
// Backpressure: accepts only in IDLE; result and out_valid held stable in HOLD until out_ready.
module mul_stage2 #(
    parameter logic [7:0] C = 8'd5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] s0,
    input  logic [7:0] s1,
    input  logic [7:0] s2,
    input  logic [7:0] s3,
    input  logic [7:0] s4,
    input  logic [7:0] s5,
    input  logic [7:0] s6,
    input  logic [7:0] s7,
    input  logic [7:0] s8,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] r0,
    output logic [7:0] r1,
    output logic [7:0] r2,
    output logic [7:0] r3,
    output logic [7:0] r4
);

    localparam logic [40:0] P_MOD = {1'b1, 40'd0} - {33'd0, C};

    typedef enum logic [2:0] {
        IDLE,
        FOLD1,
        FOLD2,
        FINAL,
        HOLD
    } state_t;

    state_t      state, state_nxt;
    logic [71:0] p_reg;
    logic [40:0] acc;
    logic [39:0] res;
    logic [39:0] hi_prod;
    logic [40:0] fold1_sum;
    logic [40:0] fold2_sum;
    logic [39:0] sub_res;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);

    // High half is weighted by 2^40 == C (mod p), so it folds down as H*C.
    assign hi_prod   = {8'd0, p_reg[71:40]} * {32'd0, C};
    assign fold1_sum = {1'b0, p_reg[39:0]} + {1'b0, hi_prod};
    assign fold2_sum = {1'b0, acc[39:0]} + (acc[40] ? {33'd0, C} : 41'd0);
    assign sub_res   = acc[39:0] - P_MOD[39:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = FOLD1;
            FOLD1:   state_nxt = FOLD2;
            FOLD2:   state_nxt = FINAL;
            FINAL:   state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_reg <= 72'd0;
            acc   <= 41'd0;
            res   <= 40'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        p_reg <= {s8, s7, s6, s5, s4, s3, s2, s1, s0};
                    end
                end
                FOLD1: acc <= fold1_sum;
                FOLD2: acc <= fold2_sum;
                FINAL: begin
                    // After FOLD2 acc < 2^40 < 2p, so one conditional subtract fully reduces.
                    if (acc >= P_MOD) begin
                        res <= sub_res;
                    end else begin
                        res <= acc[39:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign r0 = res[7:0];
    assign r1 = res[15:8];
    assign r2 = res[23:16];
    assign r3 = res[31:24];
    assign r4 = res[39:32];

endmodule

// File: tb/tb_mul_stage2.sv
// Directed-vector bench for mul_stage2 (C = 5): reset, reduction cases, latency, backpressure, abort.
module tb_mul_stage2;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] r0, r1, r2, r3, r4;
    logic [71:0] pin;

    int n_checks = 0;
    int n_fail   = 0;

    mul_stage2 #(.C(8'd5)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .s0(pin[7:0]),
        .s1(pin[15:8]),
        .s2(pin[23:16]),
        .s3(pin[31:24]),
        .s4(pin[39:32]),
        .s5(pin[47:40]),
        .s6(pin[55:48]),
        .s7(pin[63:56]),
        .s8(pin[71:64]),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .r0(r0),
        .r1(r1),
        .r2(r2),
        .r3(r3),
        .r4(r4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] res_vec();
        return {24'd0, r4, r3, r2, r1, r0};
    endfunction

    // Called at posedge+1 with the block in IDLE; returns at accept edge + 1.
    task automatic send(input logic [71:0] p);
        pin      = p;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 12) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [71:0] p, input logic [39:0] exp_r);
        int cyc;
        send(p);
        wait_out(cyc);
        check_val({tag, "_lat"}, 64'(cyc), 64'd3);
        check_val({tag, "_res"}, res_vec(), {24'd0, exp_r});
        @(posedge clk);
        #1;
        check_val({tag, "_inrdy"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int cyc;
        int pulses;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pin       = 72'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ovalid", 64'(out_valid), 64'd0);
        check_val("rst_res", res_vec(), 64'd0);
        reset = 1'b0;
        check_val("rst_inrdy", 64'(in_ready), 64'd1);

        // Plain low value, no reduction needed.
        run_op("basic", 72'h3412, 40'h0000003412);
        check_val("basic_ovalid_low", 64'(out_valid), 64'd0);
        check_val("basic_res_kept", res_vec(), 64'h3412);

        run_op("p2_40", 72'h01_0000000000, 40'h0000000005);
        run_op("final_sub", 72'h00_FFFFFFFFFF, 40'h0000000004);
        run_op("all_ff", {72{1'b1}}, 40'h04FFFFFFFF);

        // Backpressure: 2^40 + 7 -> 12, consumer stalls 3 cycles, extra input must be ignored.
        out_ready = 1'b0;
        send(72'h01_0000000007);
        wait_out(cyc);
        check_val("bp_lat", 64'(cyc), 64'd3);
        pin      = {72{1'b1}};
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_val("bp_ovalid", 64'(out_valid), 64'd1);
            check_val("bp_res", res_vec(), 64'h0C);
            check_val("bp_inrdy", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("bp_release_ovalid", 64'(out_valid), 64'd0);
        check_val("bp_release_inrdy", 64'(in_ready), 64'd1);
        pulses = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check_val("bp_ignored_input", 64'(pulses), 64'd0);

        // Abort while in FOLD1.
        send({72{1'b1}});
        #2;
        reset = 1'b1;
        #1;
        check_val("abort_ovalid", 64'(out_valid), 64'd0);
        check_val("abort_res", res_vec(), 64'd0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        pulses = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check_val("abort_no_pulse", 64'(pulses), 64'd0);
        run_op("after_abort", 72'h3412, 40'h0000003412);

        // Asynchronous reset mid-cycle while holding a result.
        out_ready = 1'b0;
        send(72'h01_0000000000);
        wait_out(cyc);
        check_val("hold_res", res_vec(), 64'h05);
        #3;
        reset = 1'b1;
        #1;
        check_val("async_ovalid", 64'(out_valid), 64'd0);
        check_val("async_res", res_vec(), 64'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        check_val("async_inrdy", 64'(in_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
